// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO.
// Sticky overrun/frame_err flags; reception never waits on the reader.
//
// state   | meaning
// IDLE    | line idle, watching for a synchronized 1->0 edge
// START   | waiting half a bit to confirm the start bit
// DATA    | sampling 8 data bits, one per bit period
// STOP    | sampling the stop bit; push on high, frame error on low
// BREAK   | stop bit was low; wait for the line to return high
module uart_rx_fifo #(
    parameter int CLK_HZ          = 100800000,
    parameter int SCLK_HZ         = 115200,
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uart_rxd,
    input  logic                     rd_req,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic [FIFO_DEPTH_BITS:0] count,
    output logic                     overrun,
    output logic                     frame_err,
    input  logic                     clear_err
);

    localparam int DIV   = CLK_HZ / SCLK_HZ;
    localparam int HALF  = DIV / 2;
    localparam int TW    = $clog2(DIV + 1);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic rxd_meta, rxd_sync, rxd_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick, fall, push, stop_bad;

    assign tick     = (timer == '0);
    assign fall     = rxd_prev & ~rxd_sync;
    assign push     = (state == S_STOP) && tick && rxd_sync;
    assign stop_bad = (state == S_STOP) && tick && !rxd_sync;

    // Down-counting bit timer; every sample point is its terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (!tick) timer <= timer - 1'b1;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        timer <= TW'(HALF - 1);
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (!rxd_sync) begin
                            state   <= S_DATA;
                            timer   <= TW'(DIV - 1);
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift <= {rxd_sync, shift[7:1]};
                        timer <= TW'(DIV - 1);
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick) state <= rxd_sync ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    if (rxd_sync) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic                       full, pop, wr_en;

    // count never exceeds DEPTH, so its MSB alone marks full.
    assign full     = count[FIFO_DEPTH_BITS];
    assign rd_valid = (count != '0);
    assign pop      = rd_req && rd_valid && !reset;
    assign wr_en    = push && (!full || pop) && !reset;
    assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (pop && !wr_en) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && full && !pop) overrun <= 1'b1;
            else if (clear_err)       overrun <= 1'b0;
            if (stop_bad)             frame_err <= 1'b1;
            else if (clear_err)       frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames, a vector table and random traffic
// checked against a queue-based model of the receive FIFO and flags.
module tb_uart_rx_fifo;

    localparam int BIT = 16;

    logic       clk, reset, uart_rxd, rd_req, clear_err;
    logic [7:0] rd_data;
    logic       rd_valid, overrun, frame_err;
    logic [4:0] count;

    uart_rx_fifo #(.CLK_HZ(1600), .SCLK_HZ(100), .FIFO_DEPTH_BITS(4)) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .overrun(overrun), .frame_err(frame_err), .clear_err(clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] q[$];
    logic       m_ovr, m_fe;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         npop;
        int         exp_count;
        logic [7:0] exp_head;
        logic       exp_fe;
        logic       exp_ovr;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " count"}, count, q.size());
        chk({tag, " rd_valid"}, rd_valid, q.size() != 0);
        if (q.size() != 0) chk({tag, " rd_data"}, rd_data, q[0]);
        chk({tag, " overrun"}, overrun, m_ovr);
        chk({tag, " frame_err"}, frame_err, m_fe);
    endtask

    task automatic do_reset();
        reset = 1'b1; rd_req = 1'b0; clear_err = 1'b0; uart_rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        q.delete(); m_ovr = 1'b0; m_fe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one(input string tag);
        chk({tag, " pop head"}, rd_data, q[0]);
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        void'(q.pop_front());
    endtask

    task automatic clr();
        clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
        m_ovr = 1'b0; m_fe = 1'b0;
    endtask

    // mode 0: plain; 1: check push latency around the stop sample (empty FIFO);
    // 2: rd_req during the stop-sample cycle; 3: clear_err during that cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rxd = bits[k];
            for (int c = 0; c < BIT; c++) begin
                @(posedge clk);
                if (k == 9 && c == 9) begin
                    if (mode == 1) begin
                        @(negedge clk);
                        chk("latency count at stop sample", count, 0);
                    end else if (mode == 2) #1 rd_req = 1'b1;
                    else if (mode == 3) #1 clear_err = 1'b1;
                end
                if (k == 9 && c == 10) begin
                    if (mode == 1) begin
                        @(negedge clk);
                        chk("latency count", count, 1);
                        chk("latency rd_valid", rd_valid, 1);
                        chk("latency rd_data", rd_data, b);
                        chk("latency flags", {overrun, frame_err}, 0);
                    end else if (mode == 2) #1 rd_req = 1'b0;
                    else if (mode == 3) #1 clear_err = 1'b0;
                end
            end
            #1;
        end
        uart_rxd = 1'b1;
        if (mode == 2 && q.size() != 0) void'(q.pop_front());
        if (stop) begin
            if (q.size() >= 16) m_ovr = 1'b1;
            else q.push_back(b);
        end else begin
            m_fe = 1'b1;
        end
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 0, 1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 0, 2, 8'hA5, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 1, 2, 8'h3C, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 0, 2, 8'h3C, 1'b1, 1'b0};
        tbl[4] = '{8'h81, 1'b1, 2, 1, 8'h81, 1'b1, 1'b0};
        tbl[5] = '{8'h7E, 1'b1, 0, 2, 8'h81, 1'b1, 1'b0};

        do_reset();
        chk("reset count", count, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset overrun", overrun, 0);
        chk("reset frame_err", frame_err, 0);
        rd_req = 1'b1;
        idle(1);
        rd_req = 1'b0;
        chk("empty pop count", count, 0);

        // clean frame with push latency
        idle(4);
        send_frame(8'hA5, 1'b1, 1);
        idle(4);
        check_state("a5");
        pop_one("a5");

        // short glitch: false start
        uart_rxd = 1'b0;
        idle(4);
        uart_rxd = 1'b1;
        idle(40);
        check_state("glitch");

        // bad stop bit with coincident clear_err, then break and recovery
        send_frame(8'h3C, 1'b0, 3);
        uart_rxd = 1'b0;
        idle(40);
        uart_rxd = 1'b1;
        idle(6);
        check_state("break");
        send_frame(8'h11, 1'b1, 0);
        idle(4);
        check_state("after break");
        chk("after break rd_data", rd_data, 8'h11);
        clr();
        check_state("fe cleared");

        // vector table
        do_reset();
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < tbl[i].npop; j++) pop_one("tbl");
            send_frame(tbl[i].data, tbl[i].stop, 0);
            idle(4);
            chk($sformatf("tbl%0d count", i), count, tbl[i].exp_count);
            chk($sformatf("tbl%0d rd_data", i), rd_data, tbl[i].exp_head);
            chk($sformatf("tbl%0d frame_err", i), frame_err, tbl[i].exp_fe);
            chk($sformatf("tbl%0d overrun", i), overrun, tbl[i].exp_ovr);
        end

        // overrun: 17 bytes, no reads
        do_reset();
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 0);
        idle(4);
        chk("ovr count", count, 16);
        chk("ovr flag", overrun, 1);
        check_state("ovr");
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovr seq %0d", i), rd_data, i);
            pop_one("ovr");
        end
        chk("ovr drained", count, 0);
        clr();
        chk("ovr cleared", overrun, 0);

        // full FIFO with pop coincident with push
        do_reset();
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 0);
        send_frame(8'h10, 1'b1, 2);
        idle(4);
        chk("full pp count", count, 16);
        chk("full pp overrun", overrun, 0);
        check_state("full pp");
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("full pp seq %0d", i), rd_data, i);
            pop_one("full pp");
        end
        chk("full pp drained", rd_valid, 0);

        // reset during data bit 4
        do_reset();
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'hC3, 1'b0};
            for (int k = 0; k < 5; k++) begin
                uart_rxd = bits[k];
                idle(BIT);
            end
            uart_rxd = bits[5];
            idle(8);
            reset = 1'b1;
            idle(2);
            uart_rxd = 1'b1;
            reset = 1'b0;
        end
        idle(200);
        check_state("midreset");
        send_frame(8'h5A, 1'b1, 0);
        idle(4);
        check_state("midreset 5a");
        chk("midreset rd_data", rd_data, 8'h5A);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            int         npop;
            logic [7:0] b;
            logic       stop;
            int         mode;
            npop = $urandom_range(0, 2);
            for (int j = 0; j < npop; j++) if (q.size() != 0) pop_one("rnd");
            if ($urandom_range(0, 9) == 0) clr();
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            send_frame(b, stop, mode);
            idle($urandom_range(1, 6));
            check_state($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
